addacc_frame: RTL and testbench

//  Parametrised successor to the single-bit adder accumulator: word-wide a+b summed into an accumulator over a frame of DEPTH samples.

---
 rtl/addacc_frame_if.sv | 28 ++
 rtl/addacc_frame.sv | 112 +++++++++++
 tb/tb_addacc_frame.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/addacc_frame_if.sv
// Sample-in / frame-result-out bundle for addacc_frame: producer side is the
// master, the accumulator itself is the slave.
interface addacc_frame_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_W     = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] sout;
    logic                 cout;
    logic [CNT_W-1:0]     count;

    modport master (
        output in_valid, a, b, flush, out_ready,
        input  in_ready, out_valid, sout, cout, count
    );

    modport slave (
        input  in_valid, a, b, flush, out_ready,
        output in_ready, out_valid, sout, cout, count
    );
endinterface

// File: rtl/addacc_frame.sv
// Frame accumulator: sums a+b over DEPTH accepted samples (or until flush) and
// holds the frame sum and overflow flag until the sink takes them.
module addacc_frame #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int DEPTH     = 4,
    parameter bit SATURATE  = 1'b0
) (
    input logic           clk,
    input logic           rd_n,
    addacc_frame_if.slave frm_if
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = ACC_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_ACC,
        ST_DUMP
    } state_e;

    state_e               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_q;
    logic [CNT_W-1:0]     count_q;
    logic [ACC_WIDTH-1:0] sout_q;
    logic                 cout_q;
    logic                 out_valid_q;

    logic [SUM_W-1:0]     sum_ext;
    logic                 carry;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 ovf_d;
    logic                 accept;
    logic                 close_frame;
    logic [ACC_WIDTH-1:0] res_sum;
    logic                 res_ovf;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        sum_ext     = '0;
        carry       = 1'b0;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        accept      = 1'b0;
        close_frame = 1'b0;
        res_sum     = acc_q;
        res_ovf     = ovf_q;

        // One extra bit catches the carry; the operands never exceed it since ACC_WIDTH > WIDTH.
        sum_ext = SUM_W'(acc_q) + SUM_W'(frm_if.a) + SUM_W'(frm_if.b);
        carry   = sum_ext[ACC_WIDTH];
        acc_d   = (carry && SATURATE) ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
        ovf_d   = ovf_q | carry;

        accept = frm_if.in_valid && (state_q == ST_ACC);

        if (accept) begin
            close_frame = (count_q == LAST) || frm_if.flush;
            res_sum     = acc_d;
            res_ovf     = ovf_d;
        end else if ((state_q == ST_ACC) && frm_if.flush && (count_q != '0)) begin
            // A bare flush closes the open frame as-is; an empty frame is never emitted.
            close_frame = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rd_n) begin
        if (!rd_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            sout_q      <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (close_frame) begin
                        sout_q      <= res_sum;
                        cout_q      <= res_ovf;
                        out_valid_q <= 1'b1;
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                        count_q     <= '0;
                        state_q     <= ST_DUMP;
                    end else if (accept) begin
                        acc_q   <= acc_d;
                        ovf_q   <= ovf_d;
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                ST_DUMP: begin
                    // Result stays put until the sink takes it; producer traffic is ignored here.
                    if (frm_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_ACC;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    assign frm_if.in_ready  = (state_q == ST_ACC);
    assign frm_if.out_valid = out_valid_q;
    assign frm_if.sout      = sout_q;
    assign frm_if.cout      = cout_q;
    assign frm_if.count     = count_q;
endmodule

// File: tb/tb_addacc_frame.sv
// Directed bench for addacc_frame: a 16-bit wrap instance for framing/handshake,
// and 9-bit wrap and saturating instances for overflow behaviour.
module tb_addacc_frame;
    logic clk;
    logic rd_n;

    int n_cmp = 0;
    int n_err = 0;

    addacc_frame_if #(.WIDTH(8), .ACC_WIDTH(16), .CNT_W(3)) if0 ();
    addacc_frame_if #(.WIDTH(8), .ACC_WIDTH(9),  .CNT_W(3)) if1 ();
    addacc_frame_if #(.WIDTH(8), .ACC_WIDTH(9),  .CNT_W(3)) if2 ();

    addacc_frame #(.WIDTH(8), .ACC_WIDTH(16), .DEPTH(4), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rd_n(rd_n), .frm_if(if0.slave)
    );
    addacc_frame #(.WIDTH(8), .ACC_WIDTH(9), .DEPTH(4), .SATURATE(1'b0)) dut1 (
        .clk(clk), .rd_n(rd_n), .frm_if(if1.slave)
    );
    addacc_frame #(.WIDTH(8), .ACC_WIDTH(9), .DEPTH(4), .SATURATE(1'b1)) dut2 (
        .clk(clk), .rd_n(rd_n), .frm_if(if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step0(input int v, input int a, input int b, input int f);
        if0.in_valid = 1'(v);
        if0.a        = 8'(a);
        if0.b        = 8'(b);
        if0.flush    = 1'(f);
        tick();
    endtask

    task automatic step12(input int v, input int a, input int b);
        if1.in_valid = 1'(v);
        if1.a        = 8'(a);
        if1.b        = 8'(b);
        if2.in_valid = 1'(v);
        if2.a        = 8'(a);
        if2.b        = 8'(b);
        tick();
    endtask

    task automatic handshake_all();
        if0.in_valid  = 1'b0;
        if0.flush     = 1'b0;
        if1.in_valid  = 1'b0;
        if2.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        if2.out_ready = 1'b1;
        tick();
        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;
        if2.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_n = 1'b0;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.flush = 1'b0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.flush = 1'b0; if1.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.flush = 1'b0; if2.out_ready = 1'b0;

        // Reset state
        tick();
        check("rst_out_valid", 32'(if0.out_valid), 0);
        check("rst_sout",      32'(if0.sout),      0);
        check("rst_cout",      32'(if0.cout),      0);
        check("rst_count",     32'(if0.count),     0);
        check("rst_in_ready",  32'(if0.in_ready),  1);
        rd_n = 1'b1;
        tick();

        // Four back-to-back samples: 3+7+11+15 = 36
        step0(1, 1, 2, 0);
        check("fa_count1", 32'(if0.count), 1);
        step0(1, 3, 4, 0);
        check("fa_count2", 32'(if0.count), 2);
        step0(1, 5, 6, 0);
        check("fa_count3", 32'(if0.count), 3);
        check("fa_no_valid_yet", 32'(if0.out_valid), 0);
        step0(1, 7, 8, 0);
        check("fa_out_valid", 32'(if0.out_valid), 1);
        check("fa_sout",      32'(if0.sout),      36);
        check("fa_cout",      32'(if0.cout),      0);
        check("fa_count0",    32'(if0.count),     0);

        // Backpressure: producer keeps pushing, everything must hold
        for (int i = 0; i < 5; i++) begin
            step0(1, 9, 9, 1);
            check("bp_in_ready",  32'(if0.in_ready),  0);
            check("bp_out_valid", 32'(if0.out_valid), 1);
            check("bp_sout",      32'(if0.sout),      36);
            check("bp_count",     32'(if0.count),     0);
        end
        handshake_all();
        check("hs_out_valid", 32'(if0.out_valid), 0);
        check("hs_in_ready",  32'(if0.in_ready),  1);
        check("hs_sout_hold", 32'(if0.sout),      36);

        // out_ready with nothing pending changes nothing
        handshake_all();
        check("idle_rdy_valid", 32'(if0.out_valid), 0);
        check("idle_rdy_count", 32'(if0.count),     0);

        // Two samples then bare flush: 20+2 = 22
        step0(1, 10, 10, 0);
        step0(1, 1, 1, 0);
        check("fl_count2", 32'(if0.count), 2);
        step0(0, 0, 0, 1);
        check("fl_out_valid", 32'(if0.out_valid), 1);
        check("fl_sout",      32'(if0.sout),      22);
        check("fl_count0",    32'(if0.count),     0);
        handshake_all();

        // Bare flush on an empty frame is ignored
        step0(0, 0, 0, 1);
        check("fl_empty_valid", 32'(if0.out_valid), 0);
        check("fl_empty_count", 32'(if0.count),     0);
        step0(0, 0, 0, 0);
        check("fl_empty_valid2", 32'(if0.out_valid), 0);

        // Flush together with the 2nd sample: 8+4 = 12
        step0(1, 4, 4, 0);
        step0(1, 2, 2, 1);
        check("flv_out_valid", 32'(if0.out_valid), 1);
        check("flv_sout",      32'(if0.sout),      12);
        check("flv_count0",    32'(if0.count),     0);
        handshake_all();
        for (int i = 0; i < 4; i++) step0(1, 1, 1, 0);
        check("flv_next_valid", 32'(if0.out_valid), 1);
        check("flv_next_sout",  32'(if0.sout),      8);
        handshake_all();

        // 9-bit accumulators, 4x(255,255): wrap -> 504, saturate -> 511
        for (int i = 0; i < 4; i++) step12(1, 255, 255);
        check("ov_wrap_valid", 32'(if1.out_valid), 1);
        check("ov_wrap_sout",  32'(if1.sout),      504);
        check("ov_wrap_cout",  32'(if1.cout),      1);
        check("ov_sat_valid",  32'(if2.out_valid), 1);
        check("ov_sat_sout",   32'(if2.sout),      511);
        check("ov_sat_cout",   32'(if2.cout),      1);
        handshake_all();

        // Overflow flag is per frame: a small frame afterwards reports none
        for (int i = 0; i < 4; i++) step12(1, 1, 1);
        check("ov_clr_wrap_sout", 32'(if1.sout), 8);
        check("ov_clr_wrap_cout", 32'(if1.cout), 0);
        check("ov_clr_sat_sout",  32'(if2.sout), 8);
        check("ov_clr_sat_cout",  32'(if2.cout), 0);
        handshake_all();

        // Reset mid-frame at count=3
        for (int i = 0; i < 3; i++) step0(1, 5, 5, 0);
        if0.in_valid = 1'b0;
        check("mf_count3", 32'(if0.count), 3);
        rd_n = 1'b0;
        #1;
        check("mf_rst_count",     32'(if0.count),     0);
        check("mf_rst_out_valid", 32'(if0.out_valid), 0);
        check("mf_rst_sout",      32'(if0.sout),      0);
        @(negedge clk);
        rd_n = 1'b1;
        tick();

        // Reset mid-DUMP
        for (int i = 0; i < 4; i++) step0(1, 1, 1, 0);
        if0.in_valid = 1'b0;
        check("md_out_valid", 32'(if0.out_valid), 1);
        rd_n = 1'b0;
        #1;
        check("md_rst_out_valid", 32'(if0.out_valid), 0);
        check("md_rst_sout",      32'(if0.sout),      0);
        check("md_rst_cout",      32'(if0.cout),      0);
        check("md_rst_count",     32'(if0.count),     0);
        @(negedge clk);
        rd_n = 1'b1;
        tick();

        // Clean frame after reset: 5+9+13+17 = 44
        step0(1, 2, 3, 0);
        step0(1, 4, 5, 0);
        step0(1, 6, 7, 0);
        step0(1, 8, 9, 0);
        check("pr_out_valid", 32'(if0.out_valid), 1);
        check("pr_sout",      32'(if0.sout),      44);
        check("pr_cout",      32'(if0.cout),      0);
        handshake_all();
        check("pr_hs_valid",  32'(if0.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
